// File: rtl/mem_align_pkg.sv
// Shared encodings for the memory alignment unit: CPU access sizes, FSM
// states, the worst-case beat count and a helper mapping size to byte count.
package mem_align_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Worst case: a word at an odd address on a 16-bit bus.
    localparam int MAX_BEATS = 3;

    // Number of bytes moved by an access of the given size. The illegal
    // encoding maps to 4 but never reaches the bus because it faults first.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_map.sv
// Combinational lane steering for one bus beat. Works out which bus lanes the
// current beat touches, steers CPU store bytes onto them, and merges the read
// lanes of this beat into the 32-bit load result being assembled.
module mem_lane_map
    import mem_align_pkg::*;
#(
    parameter int BUS_W = 16
) (
    input  logic [1:0]                   beat_idx,
    input  logic [$clog2(BUS_W/8)-1:0]   addr_off,
    input  logic [1:0]                   size,
    input  logic [31:0]                  wdata,
    input  logic [BUS_W-1:0]             bus_rdata,
    input  logic [31:0]                  rdata_in,
    output logic [BUS_W/8-1:0]           bus_be,
    output logic [BUS_W-1:0]             bus_wdata,
    output logic [31:0]                  rdata_next
);

    localparam int BYTES = BUS_W / 8;
    localparam int LB    = $clog2(BYTES);

    logic [2:0] n_bytes;
    assign n_bytes = bytes_of(size);

    // Bus side: each lane sits at byte position pos relative to the aligned
    // base of the first beat; it carries CPU byte (pos - offset) when that
    // byte exists, otherwise it is disabled and driven to zero.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [3:0] pos;
            logic [3:0] k;
            logic       hit;
            assign pos = 4'(beat_idx) * 4'(BYTES) + 4'(gi);
            assign k   = pos - 4'(addr_off);
            assign hit = (pos >= 4'(addr_off)) && (k < 4'(n_bytes));
            assign bus_be[gi]          = hit;
            assign bus_wdata[gi*8 +: 8] = hit ? wdata[8*k[1:0] +: 8] : 8'h00;
        end
    endgenerate

    // CPU side: byte k lives at position offset+k; if that position falls in
    // the current beat, take the matching lane, otherwise keep what earlier
    // beats already merged.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [3:0]    pos_b;
            logic [LB-1:0] lane;
            logic          hit_b;
            assign pos_b = 4'(addr_off) + 4'(gi);
            assign lane  = pos_b[LB-1:0];
            assign hit_b = (3'(gi) < n_bytes) && ((pos_b >> LB) == 4'(beat_idx));
            assign rdata_next[gi*8 +: 8] = hit_b ? bus_rdata[8*lane +: 8]
                                                 : rdata_in[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_align_unit.sv
// CPU load/store front end: captures one byte/half/word access at any byte
// address, splits it into aligned beats on a BUS_W-wide req/ack bus and
// merges read data back into a zero-extended 32-bit result. Unmapped or
// illegal accesses complete immediately with a fault.
// Optional build macro MEM_ALIGN_MISALIGN_FAULT_EN: when defined, halves at
// odd addresses and words not on a 4-byte boundary fault instead of splitting.
module mem_align_unit
    import mem_align_pkg::*;
#(
    parameter int          BUS_W       = 16,
    parameter logic [31:0] MAP_LIMIT   = 32'h8000_0000,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_rw,
    input  logic [31:0]        cpu_addr,
    input  logic [1:0]         cpu_size,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_valid,
    output logic               cpu_fault,
    output logic               cpu_busy,
    output logic               bus_req,
    output logic               bus_rw,
    output logic [31:0]        bus_addr,
    output logic [BUS_W/8-1:0] bus_be,
    output logic [BUS_W-1:0]   bus_wdata,
    input  logic [BUS_W-1:0]   bus_rdata,
    input  logic               bus_ack
);

    localparam int BYTES = BUS_W / 8;
    localparam int LB    = $clog2(BYTES);

    state_e      state_reg, state_next;
    logic [31:0] addr_reg,  addr_next;
    logic        rw_reg,    rw_next;
    logic [1:0]  size_reg,  size_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [1:0]  beat_reg,  beat_next;
    logic [1:0]  last_reg,  last_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        fault_reg, fault_next;
    logic [31:0] timer_reg, timer_next;

    // Request decode, evaluated on the live CPU inputs at capture time.
    logic [2:0]  n_req;
    logic [32:0] end_addr;
    logic        misalign;
    logic        req_fault;
    logic [3:0]  span;
    logic [1:0]  req_last;

    assign n_req    = bytes_of(cpu_size);
    // One extra bit so an access running past the top of memory still
    // compares as unmapped instead of wrapping to a low address.
    assign end_addr = {1'b0, cpu_addr} + 33'(n_req) - 33'd1;

`ifdef MEM_ALIGN_MISALIGN_FAULT_EN
    assign misalign = ((cpu_size == SZ_HALF) && cpu_addr[0]) ||
                      ((cpu_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_fault = (cpu_size == SZ_ILLEGAL) ||
                       (cpu_addr >= MAP_LIMIT) ||
                       (end_addr >= {1'b0, MAP_LIMIT}) ||
                       misalign;

    // Index of the last beat: ceil((offset + n) / BYTES) - 1.
    assign span     = 4'(cpu_addr[LB-1:0]) + 4'(n_req) + 4'(BYTES - 1);
    assign req_last = 2'((span >> LB) - 4'd1);

    // Lane steering for the beat currently on the bus.
    logic [BYTES-1:0] lane_be;
    logic [BUS_W-1:0] lane_wdata;
    logic [31:0]      merged_rdata;

    mem_lane_map #(
        .BUS_W (BUS_W)
    ) u_lane_map (
        .beat_idx   (beat_reg),
        .addr_off   (addr_reg[LB-1:0]),
        .size       (size_reg),
        .wdata      (wdata_reg),
        .bus_rdata  (bus_rdata),
        .rdata_in   (rdata_reg),
        .bus_be     (lane_be),
        .bus_wdata  (lane_wdata),
        .rdata_next (merged_rdata)
    );

    // Next-state logic: capture, beat sequencing, timeout and completion.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rw_next    = rw_reg;
        size_next  = size_reg;
        wdata_next = wdata_reg;
        beat_next  = beat_reg;
        last_next  = last_reg;
        rdata_next = rdata_reg;
        fault_next = fault_reg;
        timer_next = timer_reg;

        unique case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    addr_next  = cpu_addr;
                    rw_next    = cpu_rw;
                    size_next  = cpu_size;
                    wdata_next = cpu_wdata;
                    beat_next  = 2'd0;
                    timer_next = 32'd0;
                    rdata_next = 32'd0;
                    last_next  = req_last;
                    if (req_fault) begin
                        fault_next = 1'b1;
                        state_next = DONE;
                    end else begin
                        fault_next = 1'b0;
                        state_next = BEAT;
                    end
                end
            end
            BEAT: begin
                if (bus_ack) begin
                    timer_next = 32'd0;
                    if (!rw_reg) begin
                        rdata_next = merged_rdata;
                    end
                    if (beat_reg == last_reg) begin
                        state_next = DONE;
                    end else begin
                        beat_next = beat_reg + 2'd1;
                    end
                end else if (ACK_TIMEOUT != 0) begin
                    if (timer_reg == 32'(ACK_TIMEOUT - 1)) begin
                        // Give up on this beat; partial read data is dropped.
                        state_next = DONE;
                        fault_next = 1'b1;
                        rdata_next = 32'd0;
                        timer_next = 32'd0;
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            addr_reg  <= 32'd0;
            rw_reg    <= 1'b0;
            size_reg  <= 2'd0;
            wdata_reg <= 32'd0;
            beat_reg  <= 2'd0;
            last_reg  <= 2'd0;
            rdata_reg <= 32'd0;
            fault_reg <= 1'b0;
            timer_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rw_reg    <= rw_next;
            size_reg  <= size_next;
            wdata_reg <= wdata_next;
            beat_reg  <= beat_next;
            last_reg  <= last_next;
            rdata_reg <= rdata_next;
            fault_reg <= fault_next;
            timer_reg <= timer_next;
        end
    end

    // Outputs are decoded from state so every bus field is held for as long
    // as the beat waits for its ack, and all outputs read zero when idle.
    logic        in_beat;
    logic        in_done;
    logic [31:0] beat_addr;

    assign in_beat   = (state_reg == BEAT);
    assign in_done   = (state_reg == DONE);
    assign beat_addr = {addr_reg[31:LB], {LB{1'b0}}} + (32'(beat_reg) << LB);

    assign bus_req   = in_beat;
    assign bus_rw    = in_beat & rw_reg;
    assign bus_addr  = in_beat ? beat_addr  : 32'd0;
    assign bus_be    = in_beat ? lane_be    : '0;
    assign bus_wdata = in_beat ? lane_wdata : '0;

    assign cpu_busy  = in_beat;
    assign cpu_valid = in_done;
    assign cpu_fault = in_done & fault_reg;
    assign cpu_rdata = in_done ? rdata_reg : 32'd0;

endmodule
